// File: rtl/rdma_net_pkg.sv
// Shared RDMA TX/RX network constants: header layouts, field offsets and FSM encoding
// used by the header generator, header_packer and the RX checksum checker.
package rdma_net_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam int IP_HDR_BYTES  = 20;
  localparam int UDP_HDR_BYTES = 8;

  localparam int ETH_HDR_W = 112;
  localparam int IP_HDR_W  = 160;
  localparam int UDP_HDR_W = 64;

  // ip_header field LSB positions
  localparam int IPH_VIT_LSB    = 144;
  localparam int IPH_TOTLEN_LSB = 128;
  localparam int IPH_ID_LSB     = 112;
  localparam int IPH_FRAG_LSB   = 96;
  localparam int IPH_TTL_LSB    = 88;
  localparam int IPH_PROTO_LSB  = 80;
  localparam int IPH_CSUM_LSB   = 64;
  localparam int IPH_SRCIP_LSB  = 32;
  localparam int IPH_DSTIP_LSB  = 0;

  localparam int CSUM_WORDS = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_FOLD = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] len;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [15:0] dst_port;
    logic [15:0] src_port;
  } req_t;

endpackage

// File: rtl/ip_csum16.sv
// Ones-complement 16-bit word accumulator; csum_o is the folded, inverted
// Internet checksum of every word added since the last clear.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] data_i,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_ff @(posedge clk) begin
    if (rst)        acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (add_i) acc_q <= acc_q + {4'h0, data_i};
  end

  // 20 bits hold up to 16 words; the second fold absorbs the carry of the first
  assign fold1  = {1'b0, acc_q[15:0]} + {13'h0, acc_q[19:16]};
  assign fold2  = fold1[15:0] + {15'h0, fold1[16]};
  assign csum_o = ~fold2;

endmodule

// File: rtl/udp_ip_header_gen.sv
// Builds Ethernet/IPv4/UDP headers for one TX request and hands them to
// header_packer over four independent valid/ready channels.
module udp_ip_header_gen
  import rdma_net_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 1472,
  parameter logic [7:0]  IP_TTL      = 8'h40,
  parameter logic [15:0] ID_INIT     = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_req_valid,
  output logic                 s_req_ready,
  input  logic [15:0]          req_payload_len,
  input  logic [47:0]          req_dst_mac,
  input  logic [31:0]          req_dst_ip,
  input  logic [15:0]          req_dst_port,
  input  logic [47:0]          cfg_src_mac,
  input  logic [31:0]          cfg_src_ip,
  input  logic [15:0]          cfg_src_port,
  output logic [ETH_HDR_W-1:0] eth_header,
  output logic                 eth_header_valid,
  input  logic                 eth_header_ready,
  output logic [IP_HDR_W-1:0]  ip_header,
  output logic                 ip_header_valid,
  input  logic                 ip_header_ready,
  output logic [UDP_HDR_W-1:0] udp_header,
  output logic                 udp_header_valid,
  input  logic                 udp_header_ready,
  output logic [15:0]          payload_length_bytes,
  output logic                 length_valid,
  input  logic                 length_ready,
  output logic                 err_oversize
);

  state_e               state_q;
  req_t                 req_q;
  logic [15:0]          tot_len_q, udp_len_q, id_q;
  logic [3:0]           widx_q;
  logic [3:0]           vld_q, vld_d, rdy;
  logic [ETH_HDR_W-1:0] eth_q;
  logic [IP_HDR_W-1:0]  ip_q, ip_d;
  logic [UDP_HDR_W-1:0] udp_q;
  logic [15:0]          plen_q;
  logic                 err_q;
  logic [15:0]          word, csum;
  logic                 oversize;

  assign oversize = {16'h0, req_payload_len} > 32'(MAX_PAYLOAD);

  always_comb begin
    word = '0;
    unique case (widx_q)
      4'd0:    word = IP_VER_IHL_TOS;
      4'd1:    word = tot_len_q;
      4'd2:    word = id_q;
      4'd3:    word = 16'h0000;
      4'd4:    word = {IP_TTL, IP_PROTO_UDP};
      4'd5:    word = req_q.src_ip[31:16];
      4'd6:    word = req_q.src_ip[15:0];
      4'd7:    word = req_q.dst_ip[31:16];
      4'd8:    word = req_q.dst_ip[15:0];
      default: word = '0;
    endcase
  end

  ip_csum16 u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_IDLE && s_req_valid),
    .add_i  (state_q == ST_SUM),
    .data_i (word),
    .csum_o (csum)
  );

  always_comb begin
    ip_d = '0;
    ip_d[IPH_VIT_LSB    +: 16] = IP_VER_IHL_TOS;
    ip_d[IPH_TOTLEN_LSB +: 16] = tot_len_q;
    ip_d[IPH_ID_LSB     +: 16] = id_q;
    ip_d[IPH_FRAG_LSB   +: 16] = 16'h0000;
    ip_d[IPH_TTL_LSB    +: 8]  = IP_TTL;
    ip_d[IPH_PROTO_LSB  +: 8]  = IP_PROTO_UDP;
    ip_d[IPH_CSUM_LSB   +: 16] = csum;
    ip_d[IPH_SRCIP_LSB  +: 32] = req_q.src_ip;
    ip_d[IPH_DSTIP_LSB  +: 32] = req_q.dst_ip;
  end

  // channel order {eth, ip, udp, len}; readies on already-idle channels drop out here
  assign rdy   = {eth_header_ready, ip_header_ready, udp_header_ready, length_ready};
  assign vld_d = vld_q & ~rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      tot_len_q <= '0;
      udp_len_q <= '0;
      id_q      <= ID_INIT;
      widx_q    <= '0;
      vld_q     <= '0;
      eth_q     <= '0;
      ip_q      <= '0;
      udp_q     <= '0;
      plen_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (s_req_valid) begin
          req_q     <= '{len: req_payload_len, dst_mac: req_dst_mac, src_mac: cfg_src_mac,
                         dst_ip: req_dst_ip, src_ip: cfg_src_ip,
                         dst_port: req_dst_port, src_port: cfg_src_port};
          tot_len_q <= req_payload_len + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
          udp_len_q <= req_payload_len + 16'(UDP_HDR_BYTES);
          widx_q    <= '0;
          if (oversize) err_q   <= 1'b1;
          else          state_q <= ST_SUM;
        end
        ST_SUM: begin
          widx_q <= widx_q + 4'd1;
          if (widx_q == 4'(CSUM_WORDS - 1)) state_q <= ST_FOLD;
        end
        ST_FOLD: begin
          eth_q   <= {req_q.dst_mac, req_q.src_mac, ETHERTYPE_IPV4};
          ip_q    <= ip_d;
          udp_q   <= {req_q.src_port, req_q.dst_port, udp_len_q, 16'h0000};
          plen_q  <= req_q.len;
          vld_q   <= '1;
          id_q    <= id_q + 16'd1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          vld_q <= vld_d;
          if (vld_d == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_req_ready          = (state_q == ST_IDLE);
  assign eth_header           = eth_q;
  assign ip_header            = ip_q;
  assign udp_header           = udp_q;
  assign payload_length_bytes = plen_q;
  assign {eth_header_valid, ip_header_valid, udp_header_valid, length_valid} = vld_q;
  assign err_oversize         = err_q;

endmodule

// File: tb/tb_udp_ip_header_gen.sv
// Randomized bench for udp_ip_header_gen against an arithmetic header model;
// a second instance with ID_INIT=16'hFFFF covers ID wrap.
module tb_udp_ip_header_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_req_valid;
  logic [15:0]  req_payload_len;
  logic [47:0]  req_dst_mac;
  logic [31:0]  req_dst_ip;
  logic [15:0]  req_dst_port;
  logic [47:0]  cfg_src_mac;
  logic [31:0]  cfg_src_ip;
  logic [15:0]  cfg_src_port;
  logic         eth_header_ready, ip_header_ready, udp_header_ready, length_ready;

  logic         s_req_ready, eth_header_valid, ip_header_valid, udp_header_valid, length_valid, err_oversize;
  logic [111:0] eth_header;
  logic [159:0] ip_header;
  logic [63:0]  udp_header;
  logic [15:0]  payload_length_bytes;

  logic         w_s_req_ready, w_eth_valid, w_ip_valid, w_udp_valid, w_len_valid, w_err;
  logic [111:0] w_eth_header;
  logic [159:0] w_ip_header;
  logic [63:0]  w_udp_header;
  logic [15:0]  w_plen;

  int total = 0;
  int bad   = 0;
  logic [15:0]  mid, mid2;
  logic [111:0] e_eth;
  logic [159:0] e_ip, e_ip2;
  logic [63:0]  e_udp;

  always #5 clk = ~clk;

  udp_ip_header_gen u_dut (
    .clk(clk), .rst(rst), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .req_payload_len(req_payload_len), .req_dst_mac(req_dst_mac), .req_dst_ip(req_dst_ip),
    .req_dst_port(req_dst_port), .cfg_src_mac(cfg_src_mac), .cfg_src_ip(cfg_src_ip),
    .cfg_src_port(cfg_src_port),
    .eth_header(eth_header), .eth_header_valid(eth_header_valid), .eth_header_ready(eth_header_ready),
    .ip_header(ip_header), .ip_header_valid(ip_header_valid), .ip_header_ready(ip_header_ready),
    .udp_header(udp_header), .udp_header_valid(udp_header_valid), .udp_header_ready(udp_header_ready),
    .payload_length_bytes(payload_length_bytes), .length_valid(length_valid), .length_ready(length_ready),
    .err_oversize(err_oversize)
  );

  udp_ip_header_gen #(.ID_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .s_req_valid(s_req_valid), .s_req_ready(w_s_req_ready),
    .req_payload_len(req_payload_len), .req_dst_mac(req_dst_mac), .req_dst_ip(req_dst_ip),
    .req_dst_port(req_dst_port), .cfg_src_mac(cfg_src_mac), .cfg_src_ip(cfg_src_ip),
    .cfg_src_port(cfg_src_port),
    .eth_header(w_eth_header), .eth_header_valid(w_eth_valid), .eth_header_ready(eth_header_ready),
    .ip_header(w_ip_header), .ip_header_valid(w_ip_valid), .ip_header_ready(ip_header_ready),
    .udp_header(w_udp_header), .udp_header_valid(w_udp_valid), .udp_header_ready(udp_header_ready),
    .payload_length_bytes(w_plen), .length_valid(w_len_valid), .length_ready(length_ready),
    .err_oversize(w_err)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] vld();
    return {eth_header_valid, ip_header_valid, udp_header_valid, length_valid};
  endfunction

  // RFC 1071 style: sum header words as integers, fold carries until none remain
  function automatic logic [15:0] ref_csum(input logic [15:0] tl, input logic [15:0] id,
                                           input logic [31:0] s, input logic [31:0] d);
    int unsigned acc;
    logic [15:0] r;
    acc = 32'h4500 + 32'(tl) + 32'(id) + 32'h0000 + 32'h4011 +
          32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]);
    while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
    r = acc[15:0];
    return ~r;
  endfunction

  task automatic build_exp();
    logic [15:0] tl, ul;
    tl    = req_payload_len + 16'd28;
    ul    = req_payload_len + 16'd8;
    e_eth = {req_dst_mac, cfg_src_mac, 16'h0800};
    e_ip  = {16'h4500, tl, mid,  16'h0000, 8'h40, 8'h11, ref_csum(tl, mid,  cfg_src_ip, req_dst_ip), cfg_src_ip, req_dst_ip};
    e_ip2 = {16'h4500, tl, mid2, 16'h0000, 8'h40, 8'h11, ref_csum(tl, mid2, cfg_src_ip, req_dst_ip), cfg_src_ip, req_dst_ip};
    e_udp = {cfg_src_port, req_dst_port, ul, 16'h0000};
  endtask

  task automatic set_req(input logic [15:0] len, input logic [31:0] sip, input logic [31:0] dip);
    req_payload_len = len;
    cfg_src_ip      = sip;
    req_dst_ip      = dip;
    req_dst_mac     = 48'({$urandom(), $urandom()});
    cfg_src_mac     = 48'({$urandom(), $urandom()});
    req_dst_port    = 16'($urandom());
    cfg_src_port    = 16'($urandom());
  endtask

  // returns one time unit after the accepting edge
  task automatic send();
    @(negedge clk);
    s_req_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (s_req_ready) begin
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_req_valid = 1'b0;
    chk("accept_timeout", 160'(0), 160'(1));
  endtask

  // mode 0: all readies at once; 1: staggered len,udp,eth,ip held high; 2: random
  task automatic consume(input int mode);
    logic [3:0] ev, r;
    ev = 4'hF;
    for (int c = 0; c < 300 && ev != 4'h0; c++) begin
      @(negedge clk);
      case (mode)
        0: r = 4'hF;
        1: r = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0011 : (c == 2) ? 4'b1011 : 4'b1111;
        default: r = 4'($urandom());
      endcase
      {eth_header_ready, ip_header_ready, udp_header_ready, length_ready} = r;
      @(posedge clk); #1;
      ev = ev & ~r;
      chk("vld", 160'(vld()), 160'(ev));
      chk("busy_ready", 160'(s_req_ready), 160'(ev == 4'h0));
      chk("hold_ip", ip_header, e_ip);
      chk("hold_eth", 160'(eth_header), 160'(e_eth));
    end
    if (ev != 4'h0) chk("drain_timeout", 160'(ev), 160'(0));
    @(negedge clk);
    {eth_header_ready, ip_header_ready, udp_header_ready, length_ready} = 4'h0;
  endtask

  task automatic wait_out();
    repeat (9) @(posedge clk);
    #1 chk("lat_early", 160'(vld()), 160'(0));
    @(posedge clk); #1;
    chk("lat", 160'(vld()), 160'(4'hF));
    chk("lat_wrap", 160'({w_eth_valid, w_ip_valid, w_udp_valid, w_len_valid}), 160'(4'hF));
    chk("eth", 160'(eth_header), 160'(e_eth));
    chk("ip", ip_header, e_ip);
    chk("ip_wrap", w_ip_header, e_ip2);
    chk("udp", 160'(udp_header), 160'(e_udp));
    chk("plen", 160'(payload_length_bytes), 160'(req_payload_len));
    mid  = mid + 16'd1;
    mid2 = mid2 + 16'd1;
  endtask

  task automatic frame(input int mode, input bit busy);
    build_exp();
    send();
    wait_out();
    if (busy) begin
      @(negedge clk);
      s_req_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("busy_hold", 160'(s_req_ready), 160'(0));
      chk("busy_vld", 160'(vld()), 160'(4'hF));
      s_req_valid = 1'b0;
    end
    consume(mode);
  endtask

  task automatic oversize(input logic [15:0] len);
    set_req(len, 32'($urandom()), 32'($urandom()));
    send();
    chk("err_pulse", 160'(err_oversize), 160'(1));
    chk("err_vld", 160'(vld()), 160'(0));
    chk("err_ready", 160'(s_req_ready), 160'(1));
    @(posedge clk); #1;
    chk("err_clr", 160'(err_oversize), 160'(0));
    chk("err_vld2", 160'(vld()), 160'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_vld", 160'(vld()), 160'(0));
    chk("rst_ready", 160'(s_req_ready), 160'(1));
    @(negedge clk);
    rst  = 1'b0;
    mid  = 16'h0000;
    mid2 = 16'hFFFF;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_req_valid = 1'b0;
    {eth_header_ready, ip_header_ready, udp_header_ready, length_ready} = 4'h0;
    set_req(16'd64, 32'hC0A8010A, 32'hC0A80114);
    mid  = 16'h0000;
    mid2 = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld0", 160'(vld()), 160'(0));
    chk("rst_err", 160'(err_oversize), 160'(0));
    chk("rst_ip", ip_header, 160'(0));
    chk("rst_eth", 160'(eth_header), 160'(0));
    chk("rst_udp", 160'(udp_header), 160'(0));
    chk("rst_plen", 160'(payload_length_bytes), 160'(0));
    chk("rst_sready", 160'(s_req_ready), 160'(1));

    // readies with nothing pending must not disturb anything
    @(negedge clk);
    {eth_header_ready, ip_header_ready, udp_header_ready, length_ready} = 4'hF;
    repeat (2) @(posedge clk);
    #1 chk("idle_rdy", 160'({vld(), s_req_ready}), 160'(5'b00001));
    @(negedge clk);
    {eth_header_ready, ip_header_ready, udp_header_ready, length_ready} = 4'h0;

    // known-answer frame, then same fields again while a request is held off
    set_req(16'd64, 32'hC0A8010A, 32'hC0A80114);
    frame(0, 1'b1);
    chk("t1_csum", 160'(ip_header[79:64]), 160'(16'hF722));
    chk("t1_tlen", 160'(ip_header[143:128]), 160'(16'h005C));
    chk("t1_id", 160'(ip_header[127:112]), 160'(16'h0000));
    chk("t1_ulen", 160'(udp_header[31:16]), 160'(16'h0048));
    chk("t5_id_ffff", 160'(w_ip_header[127:112]), 160'(16'hFFFF));
    frame(0, 1'b0);
    chk("t2_csum", 160'(ip_header[79:64]), 160'(16'hF721));
    chk("t2_id", 160'(ip_header[127:112]), 160'(16'h0001));
    chk("t5_id_wrap", 160'(w_ip_header[127:112]), 160'(16'h0000));

    // length boundaries, rejection keeps the ID
    set_req(16'd0, 32'($urandom()), 32'($urandom()));
    frame(1, 1'b0);
    chk("t3_tlen0", 160'(ip_header[143:128]), 160'(16'h001C));
    chk("t3_ulen0", 160'(udp_header[31:16]), 160'(16'h0008));
    oversize(16'd1473);
    set_req(16'd1472, 32'($urandom()), 32'($urandom()));
    frame(1, 1'b0);
    chk("t3_id_kept", 160'(ip_header[127:112]), 160'(16'h0003));

    // abort in ST_SUM, then in ST_OUT
    set_req(16'd100, 32'($urandom()), 32'($urandom()));
    send();
    repeat (3) @(posedge clk);
    do_reset();
    set_req(16'd64, 32'hC0A8010A, 32'hC0A80114);
    frame(2, 1'b0);
    chk("t6_csum", 160'(ip_header[79:64]), 160'(16'hF722));
    set_req(16'd200, 32'($urandom()), 32'($urandom()));
    build_exp();
    send();
    wait_out();
    do_reset();
    set_req(16'($urandom_range(0, 1472)), 32'($urandom()), 32'($urandom()));
    frame(0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 5) == 0) oversize(16'($urandom_range(1473, 65535)));
      else begin
        set_req(16'($urandom_range(0, 1472)), 32'($urandom()), 32'($urandom()));
        frame(int'($urandom_range(0, 2)), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_ip_header_gen.md
Name: udp_ip_header_gen

Overview:
Upstream stage of header_packer in the RDMA TX path. Per outgoing frame, accepts one transmit request: payload length plus destination MAC, IP and port. Builds the packed Ethernet, IPv4 and UDP header vectors, computing IP total length, UDP length, IP identification and the IPv4 header checksum. Presents the three headers and the payload length on four valid/ready channels that connect one-to-one to header_packer.

Parameters:
MAX_PAYLOAD, 1472, largest legal UDP payload in bytes; larger requests are rejected.
IP_TTL, 8'h40, TTL used in the checksum; matches the constant emitted downstream.
ID_INIT, 16'h0000, IP identification value after reset.

Ports:
clk  in  1  single clock.
rst  in  1  reset, synchronous, active-high.
s_req_valid  in  1  request valid.
s_req_ready  out  1  request ready; high only in ST_IDLE.
req_payload_len  in  16  payload bytes.
req_dst_mac  in  48  destination MAC.
req_dst_ip  in  32  destination IPv4 address.
req_dst_port  in  16  destination UDP port.
cfg_src_mac  in  48  local MAC; quasi-static, sampled at request accept.
cfg_src_ip  in  32  local IP; sampled at accept.
cfg_src_port  in  16  local UDP port; sampled at accept.
eth_header  out  112  {dst_mac[111:64], src_mac[63:16], ethertype[15:0]=16'h0800}.
eth_header_valid / eth_header_ready  out / in  1 / 1  Ethernet header channel.
ip_header  out  160  [159:144]=16'h4500, [143:128] total_len, [127:112] id, [111:96]=0, [95:88] TTL, [87:80]=8'h11, [79:64] checksum, [63:32] src_ip, [31:0] dst_ip.
ip_header_valid / ip_header_ready  out / in  1 / 1  IPv4 header channel.
udp_header  out  64  {src_port, dst_port, udp_len, csum=16'h0000}.
udp_header_valid / udp_header_ready  out / in  1 / 1  UDP header channel.
payload_length_bytes  out  16  echoed req_payload_len.
length_valid / length_ready  out / in  1 / 1  length channel.
err_oversize  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: state ST_IDLE; all *_valid = 0; err_oversize = 0; header outputs 0; ID counter = ID_INIT; accumulator 0.
- ST_IDLE: s_req_ready = 1. On s_req_valid:
  - Latch all request and cfg fields.
  - If req_payload_len > MAX_PAYLOAD: pulse err_oversize next cycle, stay in ST_IDLE, no outputs, ID not incremented.
  - Otherwise compute total_len = len + 28 and udp_len = len + 8 (16-bit, no overflow given MAX_PAYLOAD), clear the 20-bit accumulator, word index = 0, go to ST_SUM.
- ST_SUM: one cycle per 16-bit word, in order: 16'h4500, total_len, id, 16'h0000, {IP_TTL, 8'h11}, src_ip hi, src_ip lo, dst_ip hi, dst_ip lo. The checksum field counts as 0. 9 cycles, then ST_FOLD.
- ST_FOLD: sum = acc[15:0] + acc[19:16], folded again with its carry; checksum = ~sum. Register all four outputs and set all four valids. ID counter += 1, wrapping 16'hFFFF -> 16'h0000. Go to ST_OUT.
- Latency: request accepted at cycle T -> valids high at T+11.
- ST_OUT: each channel is independent. A valid clears on the cycle after valid && ready is sampled; data holds stable while valid is high. When all four are consumed (any order, any simultaneity) go to ST_IDLE. s_req_ready = 0, so a new request waits.
- Downstream registers its readies one cycle late; valids therefore stay high through that cycle by design. No re-trigger occurs because valids drop before the packer returns to its idle state.
- Readies asserted while the matching valid is 0 are ignored.
- Synchronous rst in any state aborts the frame immediately: valids drop next edge, ID restarts at ID_INIT.
- Zero-length payload is legal: total_len = 28, udp_len = 8.

Decomposition:
- Shared package rdma_net_pkg holds:
  - ETHERTYPE_IPV4 = 16'h0800, IP_VER_IHL_TOS = 16'h4500, IP_PROTO_UDP = 8'h11.
  - IP_HDR_BYTES = 20, UDP_HDR_BYTES = 8.
  - Header widths 112/160/64, and the ip_header field bit offsets above (also used by header_packer).
  - State encoding localparams.
- One sub-module, ip_csum16: a ones-complement 16-bit accumulator with clear, add and fold/invert outputs, reusable by the RX checksum checker.

Test Plan:
1. src 192.168.1.10, dst 192.168.1.20, len 64, ID 0 -> total_len 0x005C, udp_len 0x0048, checksum 0xF722, id 0x0000; valids at T+11.
2. Two back-to-back requests with the same fields -> second frame has id 0x0001 and checksum 0xF721; s_req_ready stays low until all four channels are consumed.
3. len 0 -> total_len 0x001C, udp_len 0x0008, payload_length_bytes 0; len 1473 -> err_oversize for one cycle, no valids, next good frame uses the unchanged ID.
4. Readies in staggered order (length, udp, eth, ip, one per cycle) -> each valid drops individually, data stable, ST_IDLE only after the last; a ready with valid low is ignored.
5. Preload ID 0xFFFF via ID_INIT -> frame id 0xFFFF, next frame id 0x0000.
6. Assert rst during ST_SUM and again during ST_OUT -> all valids 0 next cycle, s_req_ready = 1, ID = ID_INIT; the next request produces the correct checksum.
